// File: rtl/door_event_monitor.sv
// rtl/door_event_monitor.sv - passage decoder with BCD occupancy and alarm-episode counts
//
// Watches the turnstile controller indicators (grn, red, buzz) and the two
// presence sensors. It decodes completed passages in each direction and keeps
// a BCD occupancy count plus a saturating alarm-episode count.
//
// Ports:
//   KEY[0]              step clock, rising edge active
//   KEY[1]              asynchronous active-low reset
//   grn, red, buzz      controller indicator outputs
//   sen_in, sen_out     entry / exit presence sensors, 1 = occupied
//   HEX3, HEX2          occupancy tens / units, active-low segments a..g on bits 0..6
//   HEX4                alarm count as a hex digit
//   occ_tens, occ_units BCD occupancy
//   alarm_cnt           alarm episodes, saturating at 15
//   evt_in, evt_out     one-cycle pulse per committed entry / exit
//   full, empty         occupancy at OCC_MAX / at zero
//   ovf, unf            sticky: entry at full / exit at empty
//   state               FSM state, for debug
module door_event_monitor #(
  parameter int OCC_MAX = 99
) (
  input  logic [1:0] KEY,
  input  logic       grn,
  input  logic       red,
  input  logic       buzz,
  input  logic       sen_in,
  input  logic       sen_out,
  output logic [0:6] HEX3,
  output logic [0:6] HEX2,
  output logic [0:6] HEX4,
  output logic [3:0] occ_tens,
  output logic [3:0] occ_units,
  output logic [3:0] alarm_cnt,
  output logic       evt_in,
  output logic       evt_out,
  output logic       full,
  output logic       empty,
  output logic       ovf,
  output logic       unf,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    IN1   = 3'b001,
    IN2   = 3'b010,
    OUT1  = 3'b011,
    OUT2  = 3'b100,
    ALARM = 3'b101
  } state_t;

  localparam logic [3:0] MAX_T = 4'(OCC_MAX / 10);
  localparam logic [3:0] MAX_U = 4'(OCC_MAX % 10);

  logic   clk;
  logic   rst_n;
  state_t st;
  logic   alarm;
  logic   clear;
  logic   at_max;
  logic   at_zero;
  logic [3:0] inc_t, inc_u, dec_t, dec_u, alarm_sat;

  assign clk     = KEY[0];
  assign rst_n   = KEY[1];
  assign state   = st;
  assign alarm   = red | buzz;
  assign clear   = ~sen_in & ~sen_out;
  assign at_max  = (occ_tens == MAX_T) && (occ_units == MAX_U);
  assign at_zero = (occ_tens == 4'd0) && (occ_units == 4'd0);
  assign full    = at_max;
  assign empty   = at_zero;

  // BCD neighbours of the current count; only used when the bound allows.
  always_comb begin
    inc_t     = occ_tens;
    inc_u     = occ_units + 4'd1;
    dec_t     = occ_tens;
    dec_u     = occ_units - 4'd1;
    if (occ_units == 4'd9) begin
      inc_u = 4'd0;
      inc_t = occ_tens + 4'd1;
    end
    if (occ_units == 4'd0) begin
      dec_u = 4'd9;
      dec_t = occ_tens - 4'd1;
    end
    alarm_sat = (alarm_cnt == 4'hF) ? alarm_cnt : alarm_cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      occ_tens  <= 4'd0;
      occ_units <= 4'd0;
      alarm_cnt <= 4'd0;
      evt_in    <= 1'b0;
      evt_out   <= 1'b0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      evt_in  <= 1'b0;
      evt_out <= 1'b0;
      case (st)
        IDLE: begin
          if (alarm) begin
            st <= ALARM; alarm_cnt <= alarm_sat;
          end else if (grn & sen_in & ~sen_out) begin
            st <= IN1;
          end else if (grn & sen_out & ~sen_in) begin
            st <= OUT1;
          end
        end
        IN1: begin
          if (alarm) begin
            st <= ALARM; alarm_cnt <= alarm_sat;
          end else if (sen_out) begin
            st <= IN2;
          end else if (clear) begin
            st <= IDLE;
          end
        end
        // The commit check comes before the alarm check: a passage that has
        // fully cleared the sensors is counted even if an alarm arrives.
        IN2: begin
          if (clear) begin
            st     <= IDLE;
            evt_in <= 1'b1;
            if (at_max) begin
              ovf <= 1'b1;
            end else begin
              occ_tens  <= inc_t;
              occ_units <= inc_u;
            end
          end else if (alarm) begin
            st <= ALARM; alarm_cnt <= alarm_sat;
          end
        end
        OUT1: begin
          if (alarm) begin
            st <= ALARM; alarm_cnt <= alarm_sat;
          end else if (sen_in) begin
            st <= OUT2;
          end else if (clear) begin
            st <= IDLE;
          end
        end
        OUT2: begin
          if (clear) begin
            st      <= IDLE;
            evt_out <= 1'b1;
            if (at_zero) begin
              unf <= 1'b1;
            end else begin
              occ_tens  <= dec_t;
              occ_units <= dec_u;
            end
          end else if (alarm) begin
            st <= ALARM; alarm_cnt <= alarm_sat;
          end
        end
        ALARM: begin
          if (~alarm & clear) st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  function automatic logic [0:6] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'b0000001;
      4'h1: seg7 = 7'b1001111;
      4'h2: seg7 = 7'b0010010;
      4'h3: seg7 = 7'b0000110;
      4'h4: seg7 = 7'b1001100;
      4'h5: seg7 = 7'b0100100;
      4'h6: seg7 = 7'b0100000;
      4'h7: seg7 = 7'b0001111;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0000100;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b1100000;
      4'hC: seg7 = 7'b0110001;
      4'hD: seg7 = 7'b1000010;
      4'hE: seg7 = 7'b0110000;
      default: seg7 = 7'b0111000;
    endcase
  endfunction

  assign HEX3 = seg7(occ_tens);
  assign HEX2 = seg7(occ_units);
  assign HEX4 = seg7(alarm_cnt);

endmodule

// File: tb/tb_door_event_monitor.sv
// tb/tb_door_event_monitor.sv - scoreboard bench for door_event_monitor
module tb_door_event_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       grn = 1'b0, red = 1'b0, buzz = 1'b0, sen_in = 1'b0, sen_out = 1'b0;
  logic [1:0] key;
  logic [0:6] HEX3, HEX2, HEX4;
  logic [3:0] occ_tens, occ_units, alarm_cnt;
  logic       evt_in, evt_out, full, empty, ovf, unf;
  logic [2:0] state;

  assign key = {rst_n, clk};

  door_event_monitor #(.OCC_MAX(99)) dut (
    .KEY(key), .grn(grn), .red(red), .buzz(buzz), .sen_in(sen_in), .sen_out(sen_out),
    .HEX3(HEX3), .HEX2(HEX2), .HEX4(HEX4),
    .occ_tens(occ_tens), .occ_units(occ_units), .alarm_cnt(alarm_cnt),
    .evt_in(evt_in), .evt_out(evt_out), .full(full), .empty(empty),
    .ovf(ovf), .unf(unf), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct { bit dir; int occ; } exp_t;
  exp_t sbq[$];

  int n_cmp = 0;
  int n_err = 0;
  int occ_m = 0;
  int alarm_m = 0;
  bit ovf_m = 0;
  bit unf_m = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: seg = 7'b0000001;  1: seg = 7'b1001111;  2: seg = 7'b0010010;  3: seg = 7'b0000110;
      4: seg = 7'b1001100;  5: seg = 7'b0100100;  6: seg = 7'b0100000;  7: seg = 7'b0001111;
      8: seg = 7'b0000000;  9: seg = 7'b0000100; 10: seg = 7'b0001000; 11: seg = 7'b1100000;
      12: seg = 7'b0110001; 13: seg = 7'b1000010; 14: seg = 7'b0110000; default: seg = 7'b0111000;
    endcase
  endfunction

  task automatic step(input logic g, input logic r, input logic b, input logic si, input logic so);
    grn = g; red = r; buzz = b; sen_in = si; sen_out = so;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_entry();
    step(1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);
    if (occ_m < 99) occ_m++; else ovf_m = 1;
    sbq.push_back('{dir: 1'b0, occ: occ_m});
    step(0, 0, 0, 0, 0);
  endtask

  task automatic do_exit();
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    if (occ_m > 0) occ_m--; else unf_m = 1;
    sbq.push_back('{dir: 1'b1, occ: occ_m});
    step(0, 0, 0, 0, 0);
  endtask

  task automatic check_occ(input string tag);
    chk({tag, "_tens"}, occ_tens, occ_m / 10);
    chk({tag, "_units"}, occ_units, occ_m % 10);
  endtask

  task automatic check_reset();
    chk("rst_state", state, 0);
    check_occ("rst_occ");
    chk("rst_alarm", alarm_cnt, 0);
    chk("rst_evt", {evt_in, evt_out}, 0);
    chk("rst_flags", {ovf, unf}, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_hex2", HEX2, seg(0));
    chk("rst_hex3", HEX3, seg(0));
    chk("rst_hex4", HEX4, seg(0));
  endtask

  // Every evt pulse pops one expected passage from the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (evt_in || evt_out)) begin
      if (sbq.size() == 0) begin
        chk("evt_unexpected", {evt_in, evt_out}, 0);
      end else begin
        e = sbq.pop_front();
        chk("evt_dir", {evt_in, evt_out}, e.dir ? 2'b01 : 2'b10);
        chk("evt_occ", occ_tens * 10 + occ_units, e.occ);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check_reset();
    rst_n = 1'b1;

    do_entry();
    check_occ("first_entry");
    chk("first_hex2", HEX2, seg(1));
    chk("evt_in_hi", evt_in, 1);
    step(0, 0, 0, 0, 0);
    chk("evt_in_lo", evt_in, 0);

    while (occ_m < 9) do_entry();
    repeat (10) do_entry();
    check_occ("carry_19");
    chk("hex3_19", HEX3, seg(1));
    chk("hex2_19", HEX2, seg(9));
    while (occ_m > 10) do_exit();
    do_exit();
    check_occ("borrow_09");

    while (occ_m < 99) do_entry();
    chk("full_99", full, 1);
    chk("ovf_pre", ovf, 0);
    do_entry();
    check_occ("ovf_hold");
    chk("ovf_set", ovf, ovf_m);
    chk("full_hold", full, 1);

    while (occ_m > 0) do_exit();
    chk("empty_00", empty, 1);
    chk("unf_pre", unf, 0);
    do_exit();
    check_occ("unf_hold");
    chk("unf_set", unf, unf_m);
    chk("empty_hold", empty, 1);
    chk("ovf_sticky", ovf, 1);

    // Commit in IN2 wins over an alarm on the same edge.
    step(1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    occ_m++;
    sbq.push_back('{dir: 1'b0, occ: occ_m});
    step(0, 1, 0, 0, 0);
    chk("commit_vs_alarm_state", state, 0);
    chk("commit_vs_alarm_cnt", alarm_cnt, 0);
    step(0, 0, 0, 0, 0);

    step(1, 0, 0, 1, 0);
    chk("in1_state", state, 1);
    step(0, 1, 0, 1, 0);
    alarm_m = 1;
    chk("alarm_state", state, 5);
    chk("alarm_first", alarm_cnt, alarm_m);
    repeat (3) step(0, 1, 0, 0, 0);
    chk("alarm_held", alarm_cnt, alarm_m);
    chk("alarm_stay", state, 5);
    step(0, 0, 0, 0, 0);
    chk("alarm_exit", state, 0);
    for (int i = 2; i <= 16; i++) begin
      step(0, 0, 1, 0, 0);
      if (alarm_m < 15) alarm_m++;
      chk("alarm_cnt", alarm_cnt, alarm_m);
      step(0, 0, 0, 0, 0);
    end
    chk("alarm_hex4", HEX4, seg(15));
    check_occ("alarm_occ");

    step(1, 0, 0, 1, 0);
    chk("abort_in1", state, 1);
    step(0, 0, 0, 0, 0);
    chk("abort_idle", state, 0);
    check_occ("abort_occ");

    step(1, 0, 0, 1, 0);
    step(0, 0, 0, 1, 1);
    chk("in2_state", state, 2);
    #2 rst_n = 1'b0;
    #1;
    occ_m = 0; alarm_m = 0; ovf_m = 0; unf_m = 0;
    check_reset();
    step(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0);
    chk("post_rst_state", state, 0);
    chk("sb_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
